push_handshake_sync: RTL and testbench

- Two-phase (toggle) request/acknowledge pulse synchronizer carrying push events from the clk_src domain to a clk_dst domain.
- Unlike a plain toggle synchronizer, the source side waits for the acknowledge toggle returned from the destination before launching the next event.
- Events arriving during a transfer are queued in a saturating pending counter, so back-to-back pushes are never merged or lost until the counter overflows.
- Used wherever a FIFO push or pop strobe must cross between the UART and FIFO clocks with guaranteed one-for-one delivery.

---
 rtl/push_handshake_sync_if.sv | 30 +++
 rtl/push_handshake_sync.sv | 118 +++++++++++
 tb/tb_push_handshake_sync.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/push_handshake_sync_if.sv
`timescale 1ns/1ps
// push_handshake_sync_if: push-event strobe into the crossing plus the
// source-side status and the destination-side delivered pulse.
//
// Handshake: sig_in is a valid-only strobe with no ready. Every clk_src
// cycle it is high is exactly one event. Back-pressure is absorbed by the
// pending counter. An event arriving with the counter full is dropped and
// recorded in the sticky overflow flag. sig_out_pulse is a valid-only strobe
// in the clk_dst domain: one cycle high per delivered event.
interface push_handshake_sync_if #(
    parameter int CNT_W = 4
);
    logic             sig_in;
    logic             ovf_clr;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             sig_out_pulse;
    logic             src_wait;      // source FSM state: 0 = IDLE, 1 = WAIT

    modport master (
        output sig_in, ovf_clr,
        input  busy, pending, overflow, sig_out_pulse, src_wait
    );

    modport slave (
        input  sig_in, ovf_clr,
        output busy, pending, overflow, sig_out_pulse, src_wait
    );
endinterface

// File: rtl/push_handshake_sync.sv
`timescale 1ns/1ps
// push_handshake_sync: two-phase req/ack pulse synchronizer from clk_src to
// clk_dst. The source launches a new toggle only after the previous one has
// been acknowledged. Pushes arriving meanwhile are queued in a saturating
// counter, so every accepted event is delivered exactly once and in order.
// Only req_tog and ack_tog cross domains, each through SYNC_STAGES flops.
// SYNC_STAGES must be at least 2.
module push_handshake_sync #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_src,
    input  logic                  rst,
    input  logic                  clk_dst,
    push_handshake_sync_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } src_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Source-domain state
    logic                   req_tog;
    logic                   req_tog_n;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [CNT_W-1:0]       pending_q;
    logic [CNT_W-1:0]       pending_n;
    logic                   overflow_q;
    logic                   overflow_n;
    logic                   ovf_set;
    logic                   launch;
    src_state_t             state;

    // Destination-domain state; req_edge is also the returned ack_tog
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_edge;

    // Source registers: request toggle, queued-event count, sticky overflow
    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            req_tog    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_tog    <= req_tog_n;
            pending_q  <= pending_n;
            overflow_q <= overflow_n;
        end
    end

    // Bring the acknowledge toggle into clk_src
    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], req_edge};
        end
    end

    // Source FSM: IDLE while toggles agree; launch a live or queued event,
    // otherwise queue the live event or drop it when the counter is full
    always_comb begin
        state      = (req_tog == ack_sync[SYNC_STAGES-1]) ? IDLE : WAIT;
        launch     = 1'b0;
        ovf_set    = 1'b0;
        req_tog_n  = req_tog;
        pending_n  = pending_q;
        overflow_n = overflow_q;

        if (state == IDLE && (bus.sig_in || pending_q != '0)) begin
            launch = 1'b1;
        end

        if (launch) begin
            req_tog_n = ~req_tog;
            // A queued event goes first; a live push on the same edge takes
            // its place in the queue, so only decrement when there is none.
            if (pending_q != '0 && !bus.sig_in) begin
                pending_n = pending_q - CNT_ONE;
            end
        end else if (bus.sig_in) begin
            if (pending_q != CNT_MAX) begin
                pending_n = pending_q + CNT_ONE;
            end else begin
                ovf_set = 1'b1;
            end
        end

        // A drop in the same cycle as a clear must remain visible
        if (ovf_set) begin
            overflow_n = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_n = 1'b0;
        end
    end

    // Destination: synchronize req_tog, then keep one extra flop for edge detect
    always_ff @(posedge clk_dst or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
            req_edge <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_tog};
            req_edge <= req_sync[SYNC_STAGES-1];
        end
    end

    assign bus.busy          = (state == WAIT) || (pending_q != '0);
    assign bus.pending       = pending_q;
    assign bus.overflow      = overflow_q;
    assign bus.src_wait      = state;
    assign bus.sig_out_pulse = req_sync[SYNC_STAGES-1] ^ req_edge;

endmodule

// File: tb/tb_push_handshake_sync.sv
`timescale 1ns/1ps
// tb_push_handshake_sync: directed scenarios on two instances, one with a
// 4-bit pending counter (a) and one with a 2-bit counter (b) for overflow.
module tb_push_handshake_sync;

    // ---------------- clock / reset ----------------
    logic    clk_src = 1'b0;
    logic    clk_dst = 1'b0;
    logic    rst     = 1'b1;
    realtime src_half = 5.0;
    realtime dst_half = 12.5;

    initial begin
        forever #(src_half) clk_src = ~clk_src;
    end

    // Offset keeps clk_dst edges off the integer-ns clk_src edges
    initial begin
        #0.3;
        forever #(dst_half) clk_dst = ~clk_dst;
    end

    push_handshake_sync_if #(.CNT_W(4)) bus_a ();
    push_handshake_sync_if #(.CNT_W(2)) bus_b ();

    push_handshake_sync #(.CNT_W(4), .SYNC_STAGES(2)) dut_a (
        .clk_src (clk_src),
        .rst     (rst),
        .clk_dst (clk_dst),
        .bus     (bus_a)
    );

    push_handshake_sync #(.CNT_W(2), .SYNC_STAGES(2)) dut_b (
        .clk_src (clk_src),
        .rst     (rst),
        .clk_dst (clk_dst),
        .bus     (bus_b)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- pulse monitors ----------------
    int   dst_edges = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   wide_a = 0;
    int   wide_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always @(posedge clk_dst) begin
        dst_edges <= dst_edges + 1;
        if (bus_a.sig_out_pulse === 1'b1) cnt_a <= cnt_a + 1;
        if (bus_b.sig_out_pulse === 1'b1) cnt_b <= cnt_b + 1;
        if (bus_a.sig_out_pulse === 1'b1 && prev_a === 1'b1) wide_a <= wide_a + 1;
        if (bus_b.sig_out_pulse === 1'b1 && prev_b === 1'b1) wide_b <= wide_b + 1;
        prev_a <= bus_a.sig_out_pulse;
        prev_b <= bus_b.sig_out_pulse;
    end

    // ---------------- driver tasks ----------------
    task automatic src_cycles(input int n);
        repeat (n) @(negedge clk_src);
    endtask

    task automatic drain_a(output bit timed_out);
        int n = 0;
        while (bus_a.busy !== 1'b0 && n < 3000) begin
            @(negedge clk_src);
            n++;
        end
        timed_out = (bus_a.busy !== 1'b0);
    endtask

    task automatic drain_b(output bit timed_out);
        int n = 0;
        while (bus_b.busy !== 1'b0 && n < 3000) begin
            @(negedge clk_src);
            n++;
        end
        timed_out = (bus_b.busy !== 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int base_a;
        int base_b;
        rst = 1'b1;
        src_cycles(4);
        rst = 1'b0;
        @(negedge clk_src);
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.busy); end
        checks++; if (bus_a.pending !== 4'd0) begin errors++; $display("FAIL reset_pending_a: got %0d expected 0", bus_a.pending); end
        checks++; if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow_a: got %b expected 0", bus_a.overflow); end
        checks++; if (bus_a.sig_out_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse_a: got %b expected 0", bus_a.sig_out_pulse); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", bus_b.busy); end
        checks++; if (bus_b.pending !== 2'd0) begin errors++; $display("FAIL reset_pending_b: got %0d expected 0", bus_b.pending); end
        base_a = cnt_a;
        base_b = cnt_b;
        repeat (10) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base_a != 0) begin errors++; $display("FAIL reset_no_pulse_a: got %0d expected 0", cnt_a - base_a); end
        checks++; if (cnt_b - base_b != 0) begin errors++; $display("FAIL reset_no_pulse_b: got %0d expected 0", cnt_b - base_b); end
    endtask

    task automatic test_single_push();
        int base;
        int e0;
        int lat;
        int n;
        bit seen;
        bit to;
        src_half = 5.0;
        dst_half = 12.5;
        src_cycles(10);
        base = cnt_a;
        bus_a.sig_in = 1'b1;
        @(posedge clk_src);
        e0 = dst_edges;
        @(negedge clk_src);
        bus_a.sig_in = 1'b0;
        checks++; if (bus_a.pending !== 4'd0) begin errors++; $display("FAIL single_pending: got %0d expected 0", bus_a.pending); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus_a.busy); end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(posedge clk_dst);
            #0.1;
            n++;
            if (bus_a.sig_out_pulse === 1'b1) seen = 1'b1;
        end
        lat = dst_edges - e0;
        checks++; if (!seen) begin errors++; $display("FAIL single_pulse_seen: got 0 expected 1"); end
        checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d dst edges expected 2", lat); end
        n = 0;
        while (bus_a.sig_out_pulse !== 1'b0 && n < 50) begin
            @(posedge clk_dst);
            #0.1;
            n++;
        end
        n = 0;
        while (bus_a.busy !== 1'b0 && n < 20) begin
            @(posedge clk_src);
            #0.1;
            n++;
        end
        checks++; if (n < 1 || n > 3) begin errors++; $display("FAIL single_busy_fall: got %0d src cycles expected 1..3", n); end
        drain_a(to);
        repeat (6) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", cnt_a - base); end
        checks++; if (bus_a.pending !== 4'd0) begin errors++; $display("FAIL single_pending_end: got %0d expected 0", bus_a.pending); end
    endtask

    task automatic test_burst();
        int base;
        int prev;
        int decs;
        int n;
        bit bad;
        bit to;
        src_half = 5.0;
        dst_half = 20.0;
        src_cycles(10);
        base = cnt_a;
        bus_a.sig_in = 1'b1;
        src_cycles(5);
        bus_a.sig_in = 1'b0;
        checks++; if (bus_a.pending !== 4'd4) begin errors++; $display("FAIL burst_pending: got %0d expected 4", bus_a.pending); end
        prev = 4;
        decs = 0;
        bad = 1'b0;
        n = 0;
        while (bus_a.busy !== 1'b0 && n < 3000) begin
            @(negedge clk_src);
            n++;
            if (int'(bus_a.pending) != prev) begin
                if (int'(bus_a.pending) != prev - 1) bad = 1'b1;
                decs++;
                prev = int'(bus_a.pending);
            end
        end
        to = (bus_a.busy !== 1'b0);
        checks++; if (to) begin errors++; $display("FAIL burst_drain: got busy=1 expected busy=0 within budget"); end
        checks++; if (bad) begin errors++; $display("FAIL burst_countdown: got non-unit step expected steps of -1"); end
        checks++; if (decs != 4) begin errors++; $display("FAIL burst_decrements: got %0d expected 4", decs); end
        repeat (4) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base != 5) begin errors++; $display("FAIL burst_count: got %0d expected 5", cnt_a - base); end
    endtask

    task automatic test_overflow();
        int base;
        bit to;
        src_half = 5.0;
        dst_half = 20.0;
        src_cycles(10);
        base = cnt_b;
        bus_b.sig_in = 1'b1;
        src_cycles(6);
        bus_b.sig_in = 1'b0;
        checks++; if (bus_b.pending !== 2'd3) begin errors++; $display("FAIL ovf_pending: got %0d expected 3", bus_b.pending); end
        checks++; if (bus_b.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus_b.overflow); end
        drain_b(to);
        checks++; if (to) begin errors++; $display("FAIL ovf_drain: got busy=1 expected busy=0 within budget"); end
        repeat (4) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_b - base != 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", cnt_b - base); end
        @(negedge clk_src);
        checks++; if (bus_b.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus_b.overflow); end
        bus_b.ovf_clr = 1'b1;
        @(negedge clk_src);
        bus_b.ovf_clr = 1'b0;
        checks++; if (bus_b.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus_b.overflow); end
        // Fill to 3 queued, then drop one while clearing
        base = cnt_b;
        bus_b.sig_in = 1'b1;
        src_cycles(4);
        checks++; if (bus_b.pending !== 2'd3) begin errors++; $display("FAIL ovf_refill: got %0d expected 3", bus_b.pending); end
        checks++; if (bus_b.overflow !== 1'b0) begin errors++; $display("FAIL ovf_no_early_set: got %b expected 0", bus_b.overflow); end
        bus_b.ovf_clr = 1'b1;
        @(negedge clk_src);
        bus_b.sig_in  = 1'b0;
        bus_b.ovf_clr = 1'b0;
        checks++; if (bus_b.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_priority: got %b expected 1", bus_b.overflow); end
        drain_b(to);
        repeat (4) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_b - base != 4) begin errors++; $display("FAIL ovf_count2: got %0d expected 4", cnt_b - base); end
        @(negedge clk_src);
        bus_b.ovf_clr = 1'b1;
        @(negedge clk_src);
        bus_b.ovf_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        int base;
        int n;
        bit to;
        src_half = 5.0;
        dst_half = 20.0;
        src_cycles(10);
        base = cnt_a;
        bus_a.sig_in = 1'b1;
        src_cycles(3);
        bus_a.sig_in = 1'b0;
        checks++; if (bus_a.pending !== 4'd2) begin errors++; $display("FAIL simul_pending_pre: got %0d expected 2", bus_a.pending); end
        n = 0;
        while (bus_a.src_wait !== 1'b0 && n < 500) begin
            @(negedge clk_src);
            n++;
        end
        checks++; if (bus_a.src_wait !== 1'b0) begin errors++; $display("FAIL simul_idle_wait: got WAIT expected IDLE within budget"); end
        bus_a.sig_in = 1'b1;
        @(negedge clk_src);
        bus_a.sig_in = 1'b0;
        checks++; if (bus_a.pending !== 4'd2) begin errors++; $display("FAIL simul_pending: got %0d expected 2", bus_a.pending); end
        checks++; if (bus_a.src_wait !== 1'b1) begin errors++; $display("FAIL simul_launch: got %b expected 1", bus_a.src_wait); end
        drain_a(to);
        repeat (4) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base != 4) begin errors++; $display("FAIL simul_count: got %0d expected 4", cnt_a - base); end
    endtask

    task automatic test_fast_dst();
        int base;
        bit to;
        src_half = 15.0;
        dst_half = 2.5;
        src_cycles(6);
        base = cnt_a;
        for (int i = 0; i < 10; i++) begin
            bus_a.sig_in = 1'b1;
            @(negedge clk_src);
            bus_a.sig_in = 1'b0;
            @(negedge clk_src);
        end
        drain_a(to);
        checks++; if (to) begin errors++; $display("FAIL fast_drain: got busy=1 expected busy=0 within budget"); end
        repeat (6) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base != 10) begin errors++; $display("FAIL fast_count: got %0d expected 10", cnt_a - base); end
        checks++; if (wide_a != 0) begin errors++; $display("FAIL fast_width: got %0d wide pulses expected 0", wide_a); end
    endtask

    task automatic test_reset_mid();
        int base_a;
        int base_b;
        src_half = 5.0;
        dst_half = 20.0;
        src_cycles(6);
        bus_a.sig_in = 1'b1;
        bus_b.sig_in = 1'b1;
        src_cycles(4);
        bus_a.sig_in = 1'b0;
        src_cycles(2);
        bus_b.sig_in = 1'b0;
        checks++; if (bus_a.pending !== 4'd3) begin errors++; $display("FAIL rmid_pending_pre: got %0d expected 3", bus_a.pending); end
        checks++; if (bus_b.overflow !== 1'b1) begin errors++; $display("FAIL rmid_overflow_pre: got %b expected 1", bus_b.overflow); end
        rst = 1'b1;
        src_cycles(2);
        rst = 1'b0;
        @(negedge clk_src);
        checks++; if (bus_a.pending !== 4'd0) begin errors++; $display("FAIL rmid_pending_a: got %0d expected 0", bus_a.pending); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_a: got %b expected 0", bus_a.busy); end
        checks++; if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow_a: got %b expected 0", bus_a.overflow); end
        checks++; if (bus_b.pending !== 2'd0) begin errors++; $display("FAIL rmid_pending_b: got %0d expected 0", bus_b.pending); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_b: got %b expected 0", bus_b.busy); end
        checks++; if (bus_b.overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow_b: got %b expected 0", bus_b.overflow); end
        base_a = cnt_a;
        base_b = cnt_b;
        repeat (20) @(posedge clk_dst);
        #0.1;
        checks++; if (cnt_a - base_a != 0) begin errors++; $display("FAIL rmid_no_pulse_a: got %0d expected 0", cnt_a - base_a); end
        checks++; if (cnt_b - base_b != 0) begin errors++; $display("FAIL rmid_no_pulse_b: got %0d expected 0", cnt_b - base_b); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus_a.sig_in  = 1'b0;
        bus_a.ovf_clr = 1'b0;
        bus_b.sig_in  = 1'b0;
        bus_b.ovf_clr = 1'b0;
        test_reset();
        test_single_push();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_fast_dst();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
